// File: rtl/puzzle_pkg.sv
`timescale 1ns/1ps
// Shared tile codes, direction/state types and move helpers for the 3x3 puzzle writer.
package puzzle_pkg;

  localparam logic [3:0] TILE_BLANK = 4'hB;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SHUFFLE = 1'b1
  } state_t;

  // Entry n is slot n (row n/3, col n%3).
  typedef logic [8:0][3:0] board_t;

  localparam board_t SOLVED_BOARD = {TILE_BLANK, 4'd8, 4'd7, 4'd6, 4'd5,
                                     4'd4, 4'd3, 4'd2, 4'd1};

  function automatic logic legal_move(input logic [3:0] pos, input dir_t dir);
    logic [3:0] row;
    logic [3:0] col;
    logic       ok;
    row = pos / 4'd3;
    col = pos % 4'd3;
    case (dir)
      DIR_UP:   ok = (row != 4'd0);
      DIR_DOWN: ok = (row < 4'd2);
      DIR_LEFT: ok = (col != 4'd0);
      default:  ok = (col < 4'd2);
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] neighbour(input logic [3:0] pos, input dir_t dir);
    logic [3:0] nb;
    case (dir)
      DIR_UP:   nb = pos - 4'd3;
      DIR_DOWN: nb = pos + 4'd3;
      DIR_LEFT: nb = pos - 4'd1;
      default:  nb = pos + 4'd1;
    endcase
    return nb;
  endfunction

  function automatic dir_t inverse_dir(input dir_t dir);
    dir_t inv;
    case (dir)
      DIR_UP:   inv = DIR_DOWN;
      DIR_DOWN: inv = DIR_UP;
      DIR_LEFT: inv = DIR_RIGHT;
      default:  inv = DIR_LEFT;
    endcase
    return inv;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
// Raw button -> 2-FF synchronizer -> stability counter -> one-cycle pulse on the
// rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic pulse
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others (sync1 -> sync2 is a true 2-FF chain).
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_q <= stable;
      pulse    <= stable & ~stable_q;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/puzzle_board_writer.sv
`timescale 1ns/1ps
// Writer side of the 3x3 sliding puzzle: debounced moves, LFSR scramble, packed rows.
// Optional one-level undo (btn_undo) is built when PUZZLE_UNDO_EN is defined.
module puzzle_board_writer
  import puzzle_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         CNT_W           = 20,
  parameter int         SHUFFLE_STEPS   = 64,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_shuffle,
`ifdef PUZZLE_UNDO_EN
  input  logic        btn_undo,
`endif
  output logic [11:0] row1,
  output logic [11:0] row2,
  output logic [11:0] row3,
  output logic [3:0]  blank_pos,
  output logic [9:0]  move_count,
  output logic        solved,
  output logic        busy
);

  localparam int STEP_W = $clog2(SHUFFLE_STEPS + 1);
`ifdef PUZZLE_UNDO_EN
  localparam int NBTN = 6;
`else
  localparam int NBTN = 5;
`endif

  logic [NBTN-1:0]   btn_raw;
  logic [NBTN-1:0]   btn_pulse;
  board_t            board;
  state_t            state;
  logic [7:0]        lfsr;
  logic [STEP_W-1:0] step_cnt;
  dir_t              mv_dir;
  logic              do_move;
  logic              user_move;
  logic [3:0]        nb_pos;

`ifdef PUZZLE_UNDO_EN
  logic undo_valid;
  logic undo_move;
  dir_t last_dir;
  assign btn_raw = {btn_undo, btn_shuffle, btn_right, btn_left, btn_down, btn_up};
`else
  assign btn_raw = {btn_shuffle, btn_right, btn_left, btn_down, btn_up};
`endif

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk  (clk),
      .clr_n(clr_n),
      .btn  (btn_raw[i]),
      .pulse(btn_pulse[i])
    );
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    mv_dir    = DIR_UP;
    do_move   = 1'b0;
    user_move = 1'b0;
`ifdef PUZZLE_UNDO_EN
    undo_move = 1'b0;
`endif
    if (state == ST_SHUFFLE) begin
      mv_dir  = dir_t'(lfsr[1:0]);
      do_move = legal_move(blank_pos, mv_dir);
    end else if (!btn_pulse[4]) begin
`ifdef PUZZLE_UNDO_EN
      if (btn_pulse[5]) begin
        mv_dir    = inverse_dir(last_dir);
        do_move   = undo_valid;
        undo_move = undo_valid;
      end else
`endif
      if (|btn_pulse[3:0]) begin
        if (btn_pulse[0])      mv_dir = DIR_UP;
        else if (btn_pulse[1]) mv_dir = DIR_DOWN;
        else if (btn_pulse[2]) mv_dir = DIR_LEFT;
        else                   mv_dir = DIR_RIGHT;
        do_move   = legal_move(blank_pos, mv_dir);
        user_move = do_move;
      end
    end
  end

  assign nb_pos = neighbour(blank_pos, mv_dir);

  // NOTE: the board is nine small registers, not a RAM, so giving it an async
  // reset value is cheap and keeps the invariant true from the first cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      board      <= SOLVED_BOARD;
      blank_pos  <= 4'd8;
      move_count <= '0;
      solved     <= 1'b1;
      busy       <= 1'b0;
      state      <= ST_IDLE;
      step_cnt   <= '0;
      lfsr       <= LFSR_SEED;
`ifdef PUZZLE_UNDO_EN
      undo_valid <= 1'b0;
      last_dir   <= DIR_UP;
`endif
    end else begin
      // Fibonacci taps 8,6,5,4; free-running so button timing adds entropy.
      lfsr   <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      solved <= (board == SOLVED_BOARD);

      if (do_move) begin
        board[blank_pos] <= board[nb_pos];
        board[nb_pos]    <= TILE_BLANK;
        blank_pos        <= nb_pos;
      end

      case (state)
        ST_IDLE: begin
          if (btn_pulse[4]) begin
            state      <= ST_SHUFFLE;
            busy       <= 1'b1;
            step_cnt   <= STEP_W'(SHUFFLE_STEPS);
            move_count <= '0;
`ifdef PUZZLE_UNDO_EN
            undo_valid <= 1'b0;
`endif
          end else if (user_move) begin
            if (move_count != 10'h3FF) move_count <= move_count + 10'd1;
`ifdef PUZZLE_UNDO_EN
            undo_valid <= 1'b1;
            last_dir   <= mv_dir;
          end else if (undo_move) begin
            if (move_count != 10'd0) move_count <= move_count - 10'd1;
            undo_valid <= 1'b0;
`endif
          end
        end
        default: begin
          step_cnt <= step_cnt - 1'b1;
          if (step_cnt == STEP_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign row1 = {board[0], board[1], board[2]};
  assign row2 = {board[3], board[4], board[5]};
  assign row3 = {board[6], board[7], board[8]};

endmodule

// File: tb/tb_puzzle_board_writer.sv
`timescale 1ns/1ps
// Self-checking bench for puzzle_board_writer against a slot-array puzzle model.
module tb_puzzle_board_writer;

  localparam int         DEB   = 4;
  localparam int         SH    = 64;
  localparam logic [7:0] SEED  = 8'hA5;
  localparam int         BLANK = 11;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        btn_shuffle = 1'b0;
`ifdef PUZZLE_UNDO_EN
  logic        btn_undo = 1'b0;
`endif
  logic [11:0] row1, row2, row3;
  logic [3:0]  blank_pos;
  logic [9:0]  move_count;
  logic        solved, busy;

  int          n_checks = 0;
  int          n_fail = 0;
  int          m_board[9];
  int          m_count;
  logic [7:0]  ref_lfsr;

  always #5 clk = ~clk;

  puzzle_board_writer #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (4),
    .SHUFFLE_STEPS  (SH),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_shuffle(btn_shuffle),
`ifdef PUZZLE_UNDO_EN
    .btn_undo   (btn_undo),
`endif
    .row1       (row1),
    .row2       (row2),
    .row3       (row3),
    .blank_pos  (blank_pos),
    .move_count (move_count),
    .solved     (solved),
    .busy       (busy)
  );

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    int   taps[4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    foreach (taps[i]) fb ^= s[taps[i]-1];
    return {s[6:0], fb};
  endfunction

  // Reference LFSR: value after every clock edge since reset released.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) ref_lfsr <= SEED;
    else        ref_lfsr <= lfsr_next(ref_lfsr);
  end

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_board[i] = i + 1;
    m_board[8] = BLANK;
    m_count = 0;
  endfunction

  function automatic int m_blank();
    for (int i = 0; i < 9; i++) if (m_board[i] == BLANK) return i;
    return -1;
  endfunction

  function automatic bit m_is_solved();
    for (int i = 0; i < 8; i++) if (m_board[i] != i + 1) return 1'b0;
    return 1'b1;
  endfunction

  // dir: 0 up, 1 down, 2 left, 3 right; returns 1 if the blank moved.
  function automatic bit m_move(input int dir);
    int b = m_blank();
    int r = b / 3;
    int c = b % 3;
    int t;
    case (dir)
      0:       r = r - 1;
      1:       r = r + 1;
      2:       c = c - 1;
      default: c = c + 1;
    endcase
    if (r < 0 || r > 2 || c < 0 || c > 2) return 1'b0;
    t = r * 3 + c;
    m_board[b] = m_board[t];
    m_board[t] = BLANK;
    return 1'b1;
  endfunction

  function automatic void m_user(input logic [3:0] mask);
    for (int d = 0; d < 4; d++) begin
      if (mask[d]) begin
        if (m_move(d)) m_count = (m_count < 1023) ? m_count + 1 : 1023;
        return;
      end
    end
  endfunction

  function automatic logic [11:0] exp_row(input int r);
    int a = m_board[3*r];
    int b = m_board[3*r+1];
    int c = m_board[3*r+2];
    return {a[3:0], b[3:0], c[3:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_board(input string tag);
    check({tag, "_rows"}, {28'd0, row1, row2, row3}, {28'd0, exp_row(0), exp_row(1), exp_row(2)});
    check({tag, "_blank"}, 64'(blank_pos), 64'(m_blank()));
    check({tag, "_count"}, 64'(move_count), 64'(m_count));
  endtask

  // mask bits: 0 up, 1 down, 2 left, 3 right, 4 shuffle, 5 undo
  task automatic set_buttons(input logic [5:0] mask);
    btn_up      = mask[0];
    btn_down    = mask[1];
    btn_left    = mask[2];
    btn_right   = mask[3];
    btn_shuffle = mask[4];
`ifdef PUZZLE_UNDO_EN
    btn_undo    = mask[5];
`endif
  endtask

  task automatic press(input logic [5:0] mask, input int hold);
    set_buttons(mask);
    repeat (hold) tick();
    set_buttons(6'd0);
    repeat (14) tick();
  endtask

  task automatic do_reset();
    set_buttons(6'd0);
    clr_n = 1'b0;
    repeat (3) tick();
    clr_n = 1'b1;
    repeat (2) tick();
    m_reset();
  endtask

  initial begin
    int         n;
    int         busy_cycles;
    logic [7:0] lf;
    logic [15:0] seen;
    logic [3:0] nib;
    logic [35:0] rows;

    // Reset state
    do_reset();
    check_board("reset");
    check("reset_rows_const", {28'd0, row1, row2, row3}, {28'd0, 12'h123, 12'h456, 12'h78B});
    check("reset_solved", 64'(solved), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);

    // Up held 20 cycles: exact latency, one pulse, solved drops one cycle later
    set_buttons(6'b000001);
    n = 0;
    while (blank_pos == 4'd8 && n < 40) begin
      tick();
      n++;
    end
    check("up_latency", 64'(n), 64'(2 + DEB + 1 + 1));
    check("up_solved_same_cycle", 64'(solved), 64'd1);
    tick();
    n++;
    check("up_solved_next_cycle", 64'(solved), 64'd0);
    repeat (20 - n) tick();
    set_buttons(6'd0);
    repeat (20) tick();
    m_user(4'b0001);
    check_board("up_held");
    check("up_rows_const", {40'd0, row2, row3}, {40'd0, 12'h45B, 12'h786});

    // Illegal moves from the solved layout
    do_reset();
    press(6'b001010, 8);
    press(6'b000010, 8);
    press(6'b001000, 8);
    check_board("illegal");

    // Left then right returns to solved
    do_reset();
    press(6'b000100, 8);
    m_user(4'b0100);
    check_board("left");
    check("left_solved", 64'(solved), 64'd0);
    press(6'b001000, 8);
    m_user(4'b1000);
    check_board("left_right");
    check("left_right_solved", 64'(solved), 64'd1);

    // Priority: up beats left in the same cycle
    do_reset();
    press(6'b000101, 8);
    m_user(4'b0101);
    check_board("prio_up_left");

    // Shuffle: busy exactly SH cycles, up ignored, board follows the LFSR model
    set_buttons(6'b010000);
    n = 0;
    while (busy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("shuffle_start", 64'(busy), 64'd1);
    lf = ref_lfsr;
    m_count = 0;
    for (int k = 0; k < SH; k++) begin
      void'(m_move(int'(lf[1:0])));
      lf = lfsr_next(lf);
    end
    set_buttons(6'b000001);
    busy_cycles = 1;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
      if (busy === 1'b1) busy_cycles++;
      if (n == 10) set_buttons(6'd0);
    end
    check("shuffle_busy_len", 64'(busy_cycles), 64'(SH));
    repeat (20) tick();
    check_board("shuffle");
    check("shuffle_solved", 64'(solved), 64'(m_is_solved()));
    rows = {row1, row2, row3};
    seen = '0;
    for (int i = 0; i < 9; i++) begin
      nib = rows[35 - 4*i -: 4];
      seen[nib] = 1'b1;
    end
    check("shuffle_permutation", 64'(seen), 64'h09FE);

    // Random button combinations against the model
    for (int i = 0; i < 40; i++) begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      press({2'b00, mask}, $urandom_range(8, 14));
      m_user(mask);
      check_board($sformatf("rand%0d", i));
    end
    check("rand_solved", 64'(solved), 64'(m_is_solved()));

    // Asynchronous reset in the middle of a shuffle
    set_buttons(6'b010000);
    n = 0;
    while (busy !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    repeat (10) tick();
    check("midshuffle_busy", 64'(busy), 64'd1);
    clr_n = 1'b0;
    #2;
    m_reset();
    check_board("midshuffle_reset");
    check("midshuffle_reset_busy", 64'(busy), 64'd0);
    check("midshuffle_reset_solved", 64'(solved), 64'd1);
    do_reset();

`ifdef PUZZLE_UNDO_EN
    // Undo restores the previous board once; a second undo is a no-op
    press(6'b000001, 8);
    m_user(4'b0001);
    check_board("undo_pre");
    press(6'b100000, 8);
    m_reset();
    check_board("undo_once");
    check("undo_solved", 64'(solved), 64'd1);
    press(6'b100000, 8);
    check_board("undo_twice");
    do_reset();
`endif

    // move_count saturates at 1023
    for (int i = 0; i < 1023; i++) begin
      logic [3:0] mask;
      mask = (i % 2 == 0) ? 4'b0100 : 4'b1000;
      press({2'b00, mask}, 8);
      m_user(mask);
    end
    check_board("sat_1023");
    check("sat_1023_const", 64'(move_count), 64'd1023);
    press(6'b001000, 8);
    m_user(4'b1000);
    check_board("sat_hold");
    check("sat_hold_const", 64'(move_count), 64'd1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
